cmd_dispatch: RTL and testbench

CMD_DISPATCH -- requirements
Module: cmd_dispatch

---
 rtl/cmd_dispatch.sv | 130 +++++++++++++
 tb/tb_cmd_dispatch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - command FIFO feeding a request/acknowledge slave port with timed retries and drop counting
`timescale 1ns/1ps
module cmd_dispatch #(
    parameter int DEPTH     = 4,
    parameter int RETRY_GAP = 40,
    parameter int MAX_TRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [5:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_rqst,
    input  logic        cmd_ack,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL   = (AW + 1)'(DEPTH);
    localparam logic [7:0]  GAP_LD = 8'(RETRY_GAP);
    localparam logic [7:0]  TRY_MX = 8'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, RQST, CHECK, GAP} state_t;

    logic [37:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    state_t        state_q;
    logic [5:0]    cmd_addr_q;
    logic [31:0]   cmd_data_q;
    logic          cmd_rqst_q;
    logic [7:0]    tries_q, gap_q, drop_q;
    logic          push, pop;

    assign in_ready = !rst && (count_q != FULL);
    assign push     = in_valid && in_ready;
    // The head leaves the FIFO only once it is acked or has used up its tries.
    assign pop      = (state_q == CHECK) && (cmd_ack || tries_q == TRY_MX);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            cmd_rqst_q <= 1'b0;
            tries_q    <= '0;
            gap_q      <= '0;
            drop_q     <= '0;
        end else begin
            cmd_rqst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        {cmd_addr_q, cmd_data_q} <= mem_q[rd_ptr_q];
                        tries_q    <= '0;
                        cmd_rqst_q <= 1'b1;
                        state_q    <= RQST;
                    end
                end
                RQST: begin
                    tries_q <= tries_q + 8'd1;
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (cmd_ack) begin
                        state_q <= IDLE;
                    end else if (tries_q == TRY_MX) begin
                        if (drop_q != 8'hFF) begin
                            drop_q <= drop_q + 8'd1;
                        end
                        state_q <= IDLE;
                    end else begin
                        gap_q   <= GAP_LD;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    gap_q <= gap_q - 8'd1;
                    if (gap_q == 8'd1) begin
                        cmd_rqst_q <= 1'b1;
                        state_q    <= RQST;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_addr = cmd_addr_q;
    assign cmd_data = cmd_data_q;
    assign cmd_rqst = cmd_rqst_q;
    assign drop_cnt = drop_q;
    assign busy     = !rst && ((count_q != '0) || (state_q != IDLE));

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - directed and randomized checks of cmd_dispatch against a queue-based reference model
`timescale 1ns/1ps
module tb_cmd_dispatch;

    localparam int DEPTH     = 4;
    localparam int RETRY_GAP = 40;
    localparam int MAX_TRIES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  in_addr;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        cmd_ack;
    logic        busy;
    logic [7:0]  drop_cnt;

    logic        s_rst;
    logic        s_valid;
    logic        s_ack;
    logic        s_ready;
    logic [5:0]  s_addr;
    logic [31:0] s_data;
    logic        s_rqst;
    logic        s_busy;
    logic [7:0]  s_drop;

    always #5 clk = ~clk;

    cmd_dispatch #(.DEPTH(DEPTH), .RETRY_GAP(RETRY_GAP), .MAX_TRIES(MAX_TRIES)) u_dut (
        .clk(clk), .rst(rst),
        .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(cmd_rqst), .cmd_ack(cmd_ack),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    // Every command is dropped after one refused try: exercises drop_cnt saturation quickly.
    cmd_dispatch #(.DEPTH(2), .RETRY_GAP(1), .MAX_TRIES(1)) u_sat (
        .clk(clk), .rst(s_rst),
        .in_addr(6'h15), .in_data(32'h5A5A_0000), .in_valid(s_valid), .in_ready(s_ready),
        .cmd_addr(s_addr), .cmd_data(s_data), .cmd_rqst(s_rqst), .cmd_ack(s_ack),
        .busy(s_busy), .drop_cnt(s_drop)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [37:0] m_q[$];
    logic [37:0] m_cur;
    int m_drops, m_tries, refuse_cyc, cyc_n, n_rqst, n_pop;
    bit rq_prev, rq_cur;
    bit never_ack, rand_ack;
    int refuse_left;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit decide();
        if (never_ack) return 1'b0;
        if (refuse_left > 0) begin
            refuse_left--;
            return 1'b0;
        end
        if (rand_ack) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // One clock: account the current cycle's push/pop in the model, advance, play the slave, check outputs.
    task automatic cyc();
        bit push, pop, drop, was_rst;
        was_rst = rst;
        push = !rst && in_valid && (m_q.size() != DEPTH);
        pop  = 1'b0;
        drop = 1'b0;
        if (!rst && rq_prev) begin
            if (cmd_ack) pop = 1'b1;
            else if (m_tries == MAX_TRIES) begin
                pop  = 1'b1;
                drop = 1'b1;
            end else refuse_cyc = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (was_rst) begin
            m_q.delete();
            m_drops = 0;
            m_cur   = '0;
            m_tries = 0;
            rq_prev = 1'b0;
            rq_cur  = 1'b0;
            cmd_ack = 1'b0;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_tries = 0;
                n_pop++;
                if (drop && m_drops < 255) m_drops++;
            end
            if (push) m_q.push_back({in_addr, in_data});
            cmd_ack = rq_cur ? decide() : 1'b0;
        end
        rq_prev = rq_cur;
        rq_cur  = cmd_rqst;
        if (rq_cur) begin
            n_rqst++;
            chk("rqst_back_to_back", rq_prev, 0);
            if (m_q.size() == 0) chk("rqst_spurious", cmd_rqst, 0);
            else begin
                chk("rqst_cmd", {cmd_addr, cmd_data}, m_q[0]);
                if (m_tries > 0) chk("retry_spacing", cyc_n - refuse_cyc, RETRY_GAP + 1);
                m_tries++;
                m_cur = m_q[0];
            end
        end
        chk("cmd_hold", {cmd_addr, cmd_data}, m_cur);
        chk("in_ready", in_ready, !rst && (m_q.size() != DEPTH));
        chk("busy", busy, m_q.size() != 0);
        chk("drop_cnt", drop_cnt, m_drops);
    endtask

    task automatic push1(input logic [5:0] a, input logic [31:0] d);
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int lim);
        int g;
        g = 0;
        while (m_q.size() != 0 && g < lim) begin
            cyc();
            g++;
        end
        cyc();
        cyc();
        chk(tag, busy, 0);
    endtask

    initial begin
        int base, p0, pushed, guard;
        rst = 1'b1; s_rst = 1'b1; s_valid = 1'b1; s_ack = 1'b0;
        in_addr = '0; in_data = '0; in_valid = 1'b0; cmd_ack = 1'b0;
        m_cur = '0; m_drops = 0; m_tries = 0; refuse_cyc = 0; cyc_n = 0;
        n_rqst = 0; n_pop = 0; rq_prev = 0; rq_cur = 0;
        never_ack = 0; rand_ack = 0; refuse_left = 0;

        repeat (3) cyc();
        chk("rst_rqst", cmd_rqst, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_data", cmd_data, 0);
        rst = 1'b0;
        cyc();
        chk("ready_after_rst", in_ready, 1);

        // Single command, best-case latency
        push1(6'h09, 32'hA000_0000);
        chk("lat_n1_rqst", cmd_rqst, 0);
        cyc();
        chk("lat_n2_rqst", cmd_rqst, 1);
        chk("lat_n2_addr", cmd_addr, 6'h09);
        chk("lat_n2_data", cmd_data, 32'hA000_0000);
        cyc();
        chk("busy_in_check", busy, 1);
        cyc();
        chk("busy_after_pop", busy, 0);
        chk("data_after_pop", cmd_data, 32'hA000_0000);
        repeat (3) cyc();

        // Two refusals then an ack
        base = n_rqst; p0 = n_pop;
        refuse_left = 2;
        push1(6'h11, 32'h1234_5678);
        drain("drain_042", 400);
        chk("tries_042", n_rqst - base, 3);
        chk("pops_042", n_pop - p0, 1);
        chk("drop_042", drop_cnt, 0);

        // Never acked: dropped after MAX_TRIES, next command follows
        never_ack = 1;
        base = n_rqst; p0 = n_pop;
        push1(6'h21, 32'hDEAD_0001);
        push1(6'h22, 32'hDEAD_0002);
        guard = 0;
        while (n_pop == p0 && guard < 1500) begin
            cyc();
            guard++;
        end
        chk("drop_043_pop", n_pop - p0, 1);
        chk("drop_043_tries", n_rqst - base, MAX_TRIES);
        chk("drop_043_cnt", drop_cnt, 1);
        never_ack = 0;
        drain("drain_043", 200);
        chk("pops_043", n_pop - p0, 2);

        // Overflow with stalled slave
        never_ack = 1;
        p0 = n_pop;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) chk("ready_before_4th", in_ready, 1);
            if (i == 4) chk("ready_full", in_ready, 0);
            in_addr  = 6'(8'h30 + i);
            in_data  = 32'hC0DE_0000 + 32'(i);
            in_valid = 1'b1;
            cyc();
        end
        in_valid  = 1'b0;
        never_ack = 0;
        drain("drain_044", 600);
        chk("deliver_044", n_pop - p0, 4);

        // Reset while a refused command sits in GAP
        never_ack = 1;
        push1(6'h3F, 32'hFFFF_0000);
        guard = 0;
        while (!rq_cur && guard < 10) begin
            cyc();
            guard++;
        end
        chk("rqst_before_rst", rq_cur, 1);
        repeat (10) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst045_busy", busy, 0);
        chk("rst045_drop", drop_cnt, 0);
        for (int i = 0; i < 60; i++) begin
            cyc();
            chk("rst045_no_rqst", cmd_rqst, 0);
        end
        never_ack = 0;
        base = n_rqst;
        push1(6'h05, 32'h0BAD_CAFE);
        drain("drain_045", 50);
        chk("rst045_fresh", n_rqst - base, 1);

        // Push and pop together at occupancy 2, wrapping pointers many times
        p0 = n_pop; pushed = 0;
        push1(6'h01, 32'h4600_0001);
        push1(6'h02, 32'h4600_0002);
        guard = 0;
        while ((n_pop - p0) < 22 && guard < 400) begin
            in_valid = rq_prev && (pushed < 20);
            if (in_valid) begin
                in_addr = 6'($urandom);
                in_data = $urandom;
                pushed++;
            end
            cyc();
            guard++;
        end
        in_valid = 1'b0;
        drain("drain_046", 50);
        chk("wrap_046", n_pop - p0, 22);

        // Randomized traffic with random slave refusals
        rand_ack = 1;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_addr  = 6'($urandom);
            in_data  = $urandom;
            cyc();
        end
        in_valid = 1'b0;
        drain("drain_rand", 4000);
        rand_ack = 0;

        // drop_cnt saturation on the short-retry instance
        s_rst = 1'b0;
        repeat (780) cyc();
        chk("sat_255", s_drop, 255);
        repeat (120) cyc();
        chk("sat_hold", s_drop, 255);
        chk("sat_busy", s_busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
